mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Arbitrates the single-port unified memory between two requesters: the instruction-fetch path (IF) and the data path (DM, LDI/STI-class accesses).
- Each requester uses a req/gnt/rvalid handshake.
- The arbiter latches the winning request, drives memory strobes for MEM_LAT cycles, then returns read data with a one-cycle valid pulse.
- Sits between the controller/datapath and the memory model, replacing the direct PC/TR mux into memory.

Parameters:
ADDR_W, 13, address width of memory and both requesters
DATA_W, 8, data word width
MEM_LAT, 2, memory access cycles per transaction (legal range 1..15)

Ports:
clk  input  1  system clock, all state updates on posedge
rst  input  1  synchronous, active-high reset
if_req  input  1  fetch request; level, held until if_gnt
if_addr  input  ADDR_W  fetch address, sampled on grant cycle
if_gnt  output  1  fetch grant, one-cycle pulse
if_rvalid  output  1  fetch read data valid, one-cycle pulse
dm_req  input  1  data request; level, held until dm_gnt
dm_we  input  1  1 = write, 0 = read; sampled on grant
dm_addr  input  ADDR_W  data address, sampled on grant
dm_wdata  input  DATA_W  write data, sampled on grant
dm_gnt  output  1  data grant, one-cycle pulse
dm_rvalid  output  1  data completion pulse (read data valid, or write ack)
rdata  output  DATA_W  registered read data, shared by both requesters
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
mem_rdata  input  DATA_W  memory read data
busy  output  1  1 in any state other than IDLE

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - All outputs and internal registers clear to 0: gnt, rvalid, strobes, mem_addr, mem_wdata, rdata, latency counter, owner, last_owner.
  - A reset asserted mid-transaction aborts it. Strobes are 0 from the next edge, and no rvalid is issued for the aborted transaction.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - If any req is high, pick the winner (see arbitration).
  - Assert the winner's gnt combinationally in this cycle.
  - Latch addr, we, and wdata into registers, record owner, load counter = MEM_LAT, go to ACCESS.
  - No req: stay in IDLE.
- ACCESS:
  - mem_addr and mem_wdata are driven from the latched registers.
  - mem_read = !we_q; mem_write = we_q. Strobes are held for exactly MEM_LAT cycles; counter decrements each cycle.
  - On the last cycle (counter == 1), a read captures mem_rdata into rdata. Go to RESP.
- RESP:
  - Owner's rvalid = 1 for exactly one cycle. rdata is stable (unchanged for writes).
  - Strobes are 0. Go to IDLE.
- Latency and throughput:
  - Grant at cycle 0, strobes in cycles 1..MEM_LAT, rvalid in cycle MEM_LAT+1.
  - One transaction per MEM_LAT+2 cycles.
- Grant rules:
  - gnt is issued only in IDLE.
  - A req asserted while busy is held by the requester and considered at the next IDLE.
  - The requester may drop req or change addr/data after gnt without affecting the transaction.
- Arbitration (default): fixed priority, DM over IF. A continuously requesting DM can starve IF; this is acceptable because the controller never issues back-to-back data accesses.
- Mutual exclusion:
  - if_gnt and dm_gnt are never both 1.
  - if_rvalid and dm_rvalid are never both 1.
  - mem_read and mem_write are never both 1.
- Outside ACCESS: mem_addr and mem_wdata hold their last latched values; strobes are 0.

Optional Feature:
Macro: MEM_ARB_ROUND_ROBIN_EN
- Defined: a 1-bit last_owner register is updated at each grant. When both reqs are high in IDLE, the requester that was not granted last wins. A single request is always granted. last_owner resets to IF, so DM wins the first tie.
- Undefined: fixed DM > IF priority; no last_owner register.

Test Plan:
1. MEM_LAT=2, if_req=1, if_addr=0x010, memory returns 0xA5. Required: if_gnt at cycle 0; mem_read=1, mem_addr=0x010 in cycles 1–2; if_rvalid=1 and rdata=0xA5 at cycle 3; busy low at cycle 4.
2. Write: dm_req=1, dm_we=1, dm_addr=0x1F0, dm_wdata=0x3C. Required: mem_write=1 for 2 cycles with addr 0x1F0 and data 0x3C; dm_rvalid pulses at cycle 3; mem_read, if_rvalid, and rdata stay 0.
3. Simultaneous if_req and dm_req in IDLE, macro undefined. Required: dm_gnt first, then if_gnt in the next IDLE (cycle 4 for MEM_LAT=2). Never both gnts high.
4. With MEM_ARB_ROUND_ROBIN_EN, both reqs held high for 4 transactions. Required: grant order DM, IF, DM, IF.
5. Reset mid-access: rst=1 at cycle 2 of a read. Required: mem_read=0 from the next edge, no rvalid, busy=0, all outputs 0. A new if_req after reset completes normally.
6. if_req raised at cycle 1 while a DM read is in progress. Required: no if_gnt until IDLE at cycle 4; then the fetch completes with correct rdata, and the DM rdata pulse is unaffected.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (instruction fetch / data path) in front of a single-port memory.
// Build option MEM_ARB_ROUND_ROBIN_EN: alternate winners on ties; otherwise DM has fixed priority over IF.
module mem_port_arbiter #(
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              owner_q;      // 1 = DM owns the current transaction
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic              if_rvalid_q;
  logic              dm_rvalid_q;

  logic dm_wins;
  logic grant_ok;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_owner_q;              // 1 = DM was granted last

  always_comb begin
    dm_wins = dm_req && (!if_req || !last_owner_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner_q <= 1'b0;
    end else if (grant_ok && (dm_req || if_req)) begin
      last_owner_q <= dm_wins;
    end
  end
`else
  always_comb begin
    dm_wins = dm_req;
  end
`endif

  // Grants are combinational so the requester sees them in the cycle it wins.
  assign grant_ok = (state_q == S_IDLE) && !rst;
  assign dm_gnt   = grant_ok && dm_wins;
  assign if_gnt   = grant_ok && if_req && !dm_wins;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if_rvalid_q <= 1'b0;
          dm_rvalid_q <= 1'b0;
          if (dm_req || if_req) begin
            owner_q     <= dm_wins;
            we_q        <= dm_wins && dm_we;
            addr_q      <= dm_wins ? dm_addr : if_addr;
            if (dm_wins) begin
              wdata_q <= dm_wdata;
            end
            mem_read_q  <= !(dm_wins && dm_we);
            mem_write_q <= dm_wins && dm_we;
            cnt_q       <= LAT_INIT;
            state_q     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (cnt_q == 4'd1) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            if (!we_q) begin
              rdata_q <= mem_rdata;
            end
            if_rvalid_q <= !owner_q;
            dm_rvalid_q <= owner_q;
            cnt_q       <= 4'd0;
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          if_rvalid_q <= 1'b0;
          dm_rvalid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign if_rvalid = if_rvalid_q;
  assign dm_rvalid = dm_rvalid_q;
  assign rdata     = rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus sequences for
// arbitration order, late requests and reset during an access (MEM_LAT = 2).
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [12:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic        dm_req;
  logic        dm_we;
  logic [12:0] dm_addr;
  logic [7:0]  dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [7:0]  rdata;
  logic [12:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [7:0]  mem_rdata;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(13), .DATA_W(8), .MEM_LAT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: a handful of known locations, zero elsewhere.
  assign mem_rdata = (mem_addr == 13'h010) ? 8'hA5 :
                     (mem_addr == 13'h020) ? 8'h77 :
                     (mem_addr == 13'h021) ? 8'h88 :
                     (mem_addr == 13'h030) ? 8'h5A :
                     (mem_addr == 13'h1F0) ? 8'hEE : 8'h00;

  typedef struct {
    logic        rst, ir;
    logic [12:0] ia;
    logic        dr, dw;
    logic [12:0] da;
    logic [7:0]  dd;
    logic        ig, dg, iv, dv;
    logic [7:0]  rd;
    logic [12:0] ma;
    logic [7:0]  mwd;
    logic        mr, mw, bsy;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic rst_v, input logic ir, input logic [12:0] ia,
    input logic dr, input logic dw, input logic [12:0] da, input logic [7:0] dd,
    input logic ig, input logic dg, input logic iv, input logic dv,
    input logic [7:0] rd, input logic [12:0] ma, input logic [7:0] mwd,
    input logic mr, input logic mw, input logic bsy);
    vec_t v;
    v.rst = rst_v; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
    v.ig = ig; v.dg = dg; v.iv = iv; v.dv = dv; v.rd = rd; v.ma = ma; v.mwd = mwd;
    v.mr = mr; v.mw = mw; v.bsy = bsy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic dm_then_if(input int if_start, input logic [12:0] ia, input logic [7:0] exp_if);
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin dm_req = 1'b1; dm_we = 1'b0; dm_addr = 13'h030; end
      if (c == 1) dm_req = 1'b0;
      if (c == if_start) begin if_req = 1'b1; if_addr = ia; end
      if (c == 5) if_req = 1'b0;
      @(negedge clk);
      chk("seq_dm_gnt", dm_gnt, c == 0);
      chk("seq_if_gnt", if_gnt, c == 4);
      chk("seq_dm_rvalid", dm_rvalid, c == 3);
      chk("seq_if_rvalid", if_rvalid, c == 7);
      chk("seq_busy", busy, !(c == 0 || c == 4 || c == 8));
      if (c == 3) chk("seq_dm_rdata", rdata, 8'h5A);
      if (c == 7) chk("seq_if_rdata", rdata, exp_if);
    end
    $display("seq dm_then_if start=%0d done", if_start);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic exp_dm [4];
    int   k;

    rst = 1'b1;
    idle_inputs();

    vecs[0]  = mk(1, 0, 13'h000, 0, 0, 13'h000, 8'h00,  0, 0, 0, 0,  8'h00, 13'h000, 8'h00,  0, 0, 0);
    vecs[1]  = mk(0, 1, 13'h010, 0, 0, 13'h000, 8'h00,  1, 0, 0, 0,  8'h00, 13'h000, 8'h00,  0, 0, 0);
    vecs[2]  = mk(0, 0, 13'h055, 0, 0, 13'h000, 8'h00,  0, 0, 0, 0,  8'h00, 13'h010, 8'h00,  1, 0, 1);
    vecs[3]  = mk(0, 0, 13'h055, 0, 0, 13'h000, 8'h00,  0, 0, 0, 0,  8'h00, 13'h010, 8'h00,  1, 0, 1);
    vecs[4]  = mk(0, 0, 13'h055, 0, 0, 13'h000, 8'h00,  0, 0, 1, 0,  8'hA5, 13'h010, 8'h00,  0, 0, 1);
    vecs[5]  = mk(0, 0, 13'h000, 0, 0, 13'h000, 8'h00,  0, 0, 0, 0,  8'hA5, 13'h010, 8'h00,  0, 0, 0);
    vecs[6]  = mk(1, 0, 13'h000, 0, 0, 13'h000, 8'h00,  0, 0, 0, 0,  8'hA5, 13'h010, 8'h00,  0, 0, 0);
    vecs[7]  = mk(0, 0, 13'h000, 1, 1, 13'h1F0, 8'h3C,  0, 1, 0, 0,  8'h00, 13'h000, 8'h00,  0, 0, 0);
    vecs[8]  = mk(0, 0, 13'h000, 0, 0, 13'h000, 8'hFF,  0, 0, 0, 0,  8'h00, 13'h1F0, 8'h3C,  0, 1, 1);
    vecs[9]  = mk(0, 0, 13'h000, 0, 0, 13'h000, 8'hFF,  0, 0, 0, 0,  8'h00, 13'h1F0, 8'h3C,  0, 1, 1);
    vecs[10] = mk(0, 0, 13'h000, 0, 0, 13'h000, 8'hFF,  0, 0, 0, 1,  8'h00, 13'h1F0, 8'h3C,  0, 0, 1);
    vecs[11] = mk(0, 0, 13'h000, 0, 0, 13'h000, 8'h00,  0, 0, 0, 0,  8'h00, 13'h1F0, 8'h3C,  0, 0, 0);

    repeat (2) @(posedge clk);

    // Fetch, reset, then write: one vector per clock cycle.
    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      rst = vecs[i].rst; if_req = vecs[i].ir; if_addr = vecs[i].ia;
      dm_req = vecs[i].dr; dm_we = vecs[i].dw; dm_addr = vecs[i].da; dm_wdata = vecs[i].dd;
      @(negedge clk);
      chk("vec_if_gnt",    if_gnt,    vecs[i].ig);
      chk("vec_dm_gnt",    dm_gnt,    vecs[i].dg);
      chk("vec_if_rvalid", if_rvalid, vecs[i].iv);
      chk("vec_dm_rvalid", dm_rvalid, vecs[i].dv);
      chk("vec_rdata",     rdata,     vecs[i].rd);
      chk("vec_mem_addr",  mem_addr,  vecs[i].ma);
      chk("vec_mem_wdata", mem_wdata, vecs[i].mwd);
      chk("vec_mem_read",  mem_read,  vecs[i].mr);
      chk("vec_mem_write", mem_write, vecs[i].mw);
      chk("vec_busy",      busy,      vecs[i].bsy);
      $display("vec %0d: gnt=%b%b rvalid=%b%b rdata=%h addr=%h rd/wr=%b%b busy=%b",
               i, if_gnt, dm_gnt, if_rvalid, dm_rvalid, rdata, mem_addr, mem_read, mem_write, busy);
    end

    // Simultaneous requests, then a fetch raised while a data read is in flight.
    dm_then_if(0, 13'h020, 8'h77);
    dm_then_if(1, 13'h021, 8'h88);

    // Both requests held for four transactions.
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_dm = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_dm = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    do_reset();
    k = 0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        if_req = 1'b1; if_addr = 13'h020;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 13'h030;
      end
      @(negedge clk);
      chk("tie_excl_gnt", if_gnt & dm_gnt, 1'b0);
      chk("tie_excl_rvalid", if_rvalid & dm_rvalid, 1'b0);
      chk("tie_gnt_slot", if_gnt | dm_gnt, (c % 4) == 0);
      if ((c % 4) == 0) begin
        chk("tie_order", dm_gnt, exp_dm[k]);
        $display("tie grant %0d: dm=%b if=%b", k, dm_gnt, if_gnt);
        k++;
      end
    end
    idle_inputs();

    // Reset during the second access cycle of a fetch.
    do_reset();
    @(posedge clk); #1; if_req = 1'b1; if_addr = 13'h010;
    @(negedge clk); chk("rst_gnt", if_gnt, 1'b1);
    @(posedge clk); #1; if_req = 1'b0;
    @(negedge clk); chk("rst_c1_read", mem_read, 1'b1);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk); chk("rst_c2_read", mem_read, 1'b1);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("rst_read_off", mem_read, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_addr", mem_addr, 13'h000);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_rvalid", if_rvalid, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_no_rvalid", if_rvalid | dm_rvalid, 1'b0);
      chk("rst_idle", busy, 1'b0);
    end
    @(posedge clk); #1; if_req = 1'b1; if_addr = 13'h010;
    @(negedge clk); chk("post_rst_gnt", if_gnt, 1'b1);
    @(posedge clk); #1; if_req = 1'b0;
    @(negedge clk); chk("post_rst_read", mem_read, 1'b1); chk("post_rst_addr", mem_addr, 13'h010);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk); chk("post_rst_rvalid", if_rvalid, 1'b1); chk("post_rst_rdata", rdata, 8'hA5);
    $display("seq reset_mid_access done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
